// File: rtl/dmem_if.sv
// ---------------------------------------------------------------------------
// dmem_if -- request/response bundle for banked_dmem_ctrl.
//
// Request side : req_valid/req_ready handshake carrying req_we, req_type,
//                req_addr (byte address) and req_wdata (LSB-aligned data).
// Response side: rsp_valid one-cycle pulse with rsp_rdata and rsp_err.
// Status       : busy is high while the controller is not idle.
//
// master modport: the MEM-stage requester.
// slave  modport: the memory controller.
// ---------------------------------------------------------------------------
interface dmem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 15
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_type;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;

   modport master (
      output req_valid, req_we, req_type, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_type, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/banked_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// banked_dmem_ctrl -- byte-lane-banked data memory for the MEM stage.
//
// LANES = DATA_W/8 byte-wide banks, each with its own lane enable. Sub-word
// accesses at any byte offset are rotated onto the lanes; loads are rotated
// back to the LSB and sign/zero-extended.
//
// Ports
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : dmem_if.slave (request handshake, response pulse, busy)
//
// Configuration macro: DMEM_MISALIGN_SPLIT_EN
//   defined   : an access that crosses a word boundary is split into two
//               beats (IDLE -> BEAT2), word index wrapping at the top.
//   undefined : a crossing access enables no lanes and returns rsp_err.
// ---------------------------------------------------------------------------
module banked_dmem_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 15
) (
   input  logic  clk,
   input  logic  rst,
   dmem_if.slave bus
);
   localparam int LANES = DATA_W / 8;
   localparam int LB    = $clog2(LANES);
   localparam int WI_W  = ADDR_W - LB;
   localparam int DEPTH = 1 << WI_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
`ifdef DMEM_MISALIGN_SPLIT_EN
      S_BEAT2 = 2'd1,
`endif
      S_RESP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef DMEM_MISALIGN_SPLIT_EN
   // Request latched for beat 2 plus the beat-1 read bytes
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        type_q, type_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        cap_q [LANES];
   logic [7:0]        cap_d [LANES];
   logic              beat2_s;
`endif

   logic [ADDR_W-1:0] cur_addr_s;
   logic [2:0]        cur_type_s;
   logic              cur_we_s;
   logic [DATA_W-1:0] cur_wdata_s;
   logic              accept_s;
   logic [3:0]        size_s;
   logic              uns_s;
   logic              legal_s;
   logic [LB-1:0]     off_s;
   logic [WI_W-1:0]   word_s;
   logic              cross_s;
   logic [7:0]        wbyte_s    [LANES];
   logic [LANES-1:0]  lane_en_s;
   logic [WI_W-1:0]   lane_idx_s [LANES];
   logic [7:0]        lane_wd_s  [LANES];
   logic [7:0]        rd_byte_s  [LANES];
   logic [7:0]        byte_s;
   logic              sign_s;
   logic [DATA_W-1:0] load_data_s;

   // Reset gates acceptance so nothing is written while rst is held
   assign accept_s = bus.req_valid && (state_q == S_IDLE) && !rst;

`ifdef DMEM_MISALIGN_SPLIT_EN
   assign beat2_s = (state_q == S_BEAT2);
`endif

   // Select live request in IDLE, latched request during beat 2
   always_comb begin
`ifdef DMEM_MISALIGN_SPLIT_EN
      if (beat2_s) begin
         cur_addr_s  = addr_q;
         cur_type_s  = type_q;
         cur_we_s    = we_q;
         cur_wdata_s = wdata_q;
      end else begin
         cur_addr_s  = bus.req_addr;
         cur_type_s  = bus.req_type;
         cur_we_s    = bus.req_we;
         cur_wdata_s = bus.req_wdata;
      end
`else
      cur_addr_s  = bus.req_addr;
      cur_type_s  = bus.req_type;
      cur_we_s    = bus.req_we;
      cur_wdata_s = bus.req_wdata;
`endif
   end

   // Access type decode: size in bytes, extension, legality for this width
   always_comb begin
      size_s  = 4'd1;
      uns_s   = 1'b0;
      legal_s = 1'b1;
      case (cur_type_s)
         3'b000: size_s = 4'd1;
         3'b001: size_s = 4'd2;
         3'b010: size_s = 4'd4;
         3'b011: begin size_s = 4'd8; legal_s = (DATA_W == 64); end
         3'b100: begin size_s = 4'd1; uns_s = 1'b1; end
         3'b101: begin size_s = 4'd2; uns_s = 1'b1; end
         3'b110: begin size_s = 4'd4; uns_s = 1'b1; legal_s = (DATA_W == 64); end
         default: legal_s = 1'b0;
      endcase
   end

   assign off_s   = cur_addr_s[LB-1:0];
   assign word_s  = cur_addr_s[ADDR_W-1:LB];
   assign cross_s = (int'(off_s) + int'(size_s)) > LANES;

   // Split store data into bytes, byte 0 = LSB
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         wbyte_s[l] = cur_wdata_s[l*8 +: 8];
      end
   end

   // Lane enables, word index and write byte per bank for the current beat
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_en_s[l]  = 1'b0;
         lane_idx_s[l] = word_s;
         lane_wd_s[l]  = 8'd0;
      end
      if (accept_s && legal_s && !cross_s) begin
         for (int l = 0; l < LANES; l++) begin
            if ((l >= int'(off_s)) && (l < int'(off_s) + int'(size_s))) begin
               lane_en_s[l] = 1'b1;
               lane_wd_s[l] = wbyte_s[LB'(l - int'(off_s))];
            end else begin
               lane_en_s[l] = 1'b0;
            end
         end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      else if (accept_s && legal_s) begin
         // beat 1: lanes off..LANES-1 of word W
         for (int l = 0; l < LANES; l++) begin
            if (l >= int'(off_s)) begin
               lane_en_s[l] = 1'b1;
               lane_wd_s[l] = wbyte_s[LB'(l - int'(off_s))];
            end else begin
               lane_en_s[l] = 1'b0;
            end
         end
      end else if (beat2_s) begin
         // beat 2: low lanes of word W+1 (wraps to word 0), data continues in order
         for (int l = 0; l < LANES; l++) begin
            lane_idx_s[l] = word_s + WI_W'(1);
            if (l < int'(off_s) + int'(size_s) - LANES) begin
               lane_en_s[l] = 1'b1;
               lane_wd_s[l] = wbyte_s[LB'(l + LANES - int'(off_s))];
            end else begin
               lane_en_s[l] = 1'b0;
            end
         end
      end
`endif
      else begin
         lane_en_s = '0;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_bank
      logic [7:0] mem [DEPTH];

      // Byte bank write port; contents are deliberately not reset
      always_ff @(posedge clk) begin
         if (lane_en_s[g] && cur_we_s) begin
            mem[lane_idx_s[g]] <= lane_wd_s[g];
         end
      end

      assign rd_byte_s[g] = mem[lane_idx_s[g]];
   end

   // Load assembly: rotate bytes to LSB, then sign/zero extend
   always_comb begin
      load_data_s = '0;
      byte_s      = 8'd0;
      for (int k = 0; k < LANES; k++) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
         if (beat2_s && (int'(off_s) + k < LANES)) begin
            byte_s = cap_q[LB'(int'(off_s) + k)];
         end else begin
            byte_s = rd_byte_s[LB'(int'(off_s) + k)];
         end
`else
         byte_s = rd_byte_s[LB'(int'(off_s) + k)];
`endif
         if (k < int'(size_s)) begin
            load_data_s[k*8 +: 8] = byte_s;
         end else begin
            load_data_s[k*8 +: 8] = 8'd0;
         end
      end
      case (size_s)
         4'd1:    sign_s = load_data_s[7];
         4'd2:    sign_s = load_data_s[15];
         4'd4:    sign_s = load_data_s[31];
         default: sign_s = 1'b0;
      endcase
      if (uns_s) begin
         sign_s = 1'b0;
      end else begin
         sign_s = sign_s;
      end
      for (int k = 0; k < LANES; k++) begin
         if (k >= int'(size_s)) begin
            load_data_s[k*8 +: 8] = {8{sign_s}};
         end else begin
            load_data_s[k*8 +: 8] = load_data_s[k*8 +: 8];
         end
      end
   end

   // FSM next state, response and beat-2 latch
   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      addr_d  = addr_q;
      type_d  = type_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      for (int l = 0; l < LANES; l++) begin
         if (state_q == S_IDLE) begin
            cap_d[l] = rd_byte_s[l];
         end else begin
            cap_d[l] = cap_q[l];
         end
      end
`endif
      case (state_q)
         S_IDLE: begin
            if (!accept_s) begin
               state_d = S_IDLE;
            end else if (!legal_s) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else if (cross_s) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
               addr_d  = bus.req_addr;
               type_d  = bus.req_type;
               we_d    = bus.req_we;
               wdata_d = bus.req_wdata;
               state_d = S_BEAT2;
`else
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
`endif
            end else if (!cur_we_s) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = load_data_s;
            end else begin
               state_d = S_IDLE;
            end
         end
`ifdef DMEM_MISALIGN_SPLIT_EN
         S_BEAT2: begin
            if (we_q) begin
               state_d = S_IDLE;
            end else begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = load_data_s;
            end
         end
`endif
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
         addr_q  <= '0;
         type_q  <= 3'd0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         for (int l = 0; l < LANES; l++) begin
            cap_q[l] <= 8'd0;
         end
`endif
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_MISALIGN_SPLIT_EN
         addr_q  <= addr_d;
         type_q  <= type_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         for (int l = 0; l < LANES; l++) begin
            cap_q[l] <= cap_d[l];
         end
`endif
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
endmodule
